// File: rtl/seg7_scan_driver_if.sv
// Value/control inputs and scanned display outputs of the 4-digit 7-segment driver.
// The bench drives the master side; seg7_scan_driver is the slave.
interface seg7_scan_driver_if;
    logic [15:0] value;
    logic        dec_mode;
    logic        blank_lz;
    logic [3:0]  dp_mask;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_tick;
    logic        busy;

    modport master (
        output value, dec_mode, blank_lz, dp_mask,
        input  an, seg, dp, frame_tick, busy
    );

    modport slave (
        input  value, dec_mode, blank_lz, dp_mask,
        output an, seg, dp, frame_tick, busy
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// 4-digit multiplexed 7-segment scan driver.
// Shows a 16-bit value in hex, or in decimal via a sequential double-dabble converter.
module seg7_scan_driver #(
    parameter int REFRESH_DIV    = 50000,
    parameter bit AN_ACTIVE_LOW  = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input logic               clk,
    input logic               rst_a_p,
    seg7_scan_driver_if.slave bus
);
    localparam int         CW      = $clog2(REFRESH_DIV);
    localparam logic [3:0] AN_OFF  = AN_ACTIVE_LOW ? 4'hF : 4'h0;
    localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

    typedef enum logic {S_IDLE, S_CONV} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      idx_q, idx_d;
    logic            tick, frame, done;
    logic            blz_q, blz_d;
    logic [3:0]      dpm_q, dpm_d;
    logic [31:0]     sr_q, sr_d, adj;
    logic [3:0]      bit_q, bit_d;
    logic            over_q, over_d;
    logic [3:0][3:0] dig_q, dig_d;
    logic            dash_q, dash_d;
    logic            hi_zero, blank;
    logic [6:0]      seg_raw, seg_nxt;
    logic [3:0]      an_nxt;
    logic            dp_nxt;
    logic [3:0]      an_q;
    logic [6:0]      seg_q;
    logic            dp_q, ft_q;

    function automatic logic [6:0] hex7(input logic [3:0] d);
        case (d)
            4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
        endcase
    endfunction

    always_comb begin
        tick  = (cnt_q == CW'(REFRESH_DIV - 1));
        cnt_d = tick ? '0 : cnt_q + CW'(1);
        idx_d = tick ? idx_q + 2'd1 : idx_q;
        frame = tick && (idx_q == 2'd3);
        blz_d = frame ? bus.blank_lz : blz_q;
        dpm_d = frame ? bus.dp_mask : dpm_q;
    end

    // sr holds {bcd[15:0], bin[15:0]}; each step adds 3 to BCD nibbles >= 5, then shifts left.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        bit_d   = bit_q;
        over_d  = over_q;
        done    = 1'b0;
        adj     = sr_q;
        for (int i = 0; i < 4; i++) begin
            if (sr_q[16+4*i +: 4] >= 4'd5)
                adj[16+4*i +: 4] = sr_q[16+4*i +: 4] + 4'd3;
        end
        case (state_q)
            S_IDLE: begin
                if (frame && bus.dec_mode) begin
                    state_d = S_CONV;
                    sr_d    = {16'h0000, bus.value};
                    bit_d   = 4'd0;
                    over_d  = (bus.value > 16'd9999);
                end
            end
            S_CONV: begin
                sr_d  = adj << 1;
                bit_d = bit_q + 4'd1;
                if (bit_q == 4'd15) begin
                    state_d = S_IDLE;
                    done    = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        dig_d  = dig_q;
        dash_d = dash_q;
        if (frame && !bus.dec_mode) begin
            dig_d  = bus.value;
            dash_d = 1'b0;
        end else if (done) begin
            dig_d  = sr_d[31:16];
            dash_d = over_q;
        end
    end

    // Display for the slot being entered; at frame start hex digits/shadows are taken as they load.
    always_comb begin
        hi_zero = 1'b1;
        for (int j = 0; j < 4; j++) begin
            if ((j >= int'(idx_d)) && (dig_d[j] != 4'h0))
                hi_zero = 1'b0;
        end
        blank = blz_d && !dash_d && (idx_d != 2'd0) && hi_zero;
        if (dash_d)
            seg_raw = 7'h40;
        else if (blank)
            seg_raw = 7'h00;
        else
            seg_raw = hex7(dig_d[idx_d]);
        seg_nxt = seg_raw ^ {7{SEG_ACTIVE_LOW}};
        an_nxt  = 4'(4'b0001 << idx_d) ^ {4{AN_ACTIVE_LOW}};
        dp_nxt  = dpm_d[idx_d] ^ SEG_ACTIVE_LOW;
    end

    always_ff @(posedge clk or posedge rst_a_p) begin
        if (rst_a_p) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= 2'd3;
            blz_q   <= 1'b0;
            dpm_q   <= 4'h0;
            sr_q    <= '0;
            bit_q   <= 4'd0;
            over_q  <= 1'b0;
            dig_q   <= '0;
            dash_q  <= 1'b0;
            an_q    <= AN_OFF;
            seg_q   <= SEG_OFF;
            dp_q    <= SEG_ACTIVE_LOW;
            ft_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            blz_q   <= blz_d;
            dpm_q   <= dpm_d;
            sr_q    <= sr_d;
            bit_q   <= bit_d;
            over_q  <= over_d;
            dig_q   <= dig_d;
            dash_q  <= dash_d;
            ft_q    <= frame;
            if (tick) begin
                an_q  <= an_nxt;
                seg_q <= seg_nxt;
                dp_q  <= dp_nxt;
            end
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.frame_tick = ft_q;
    assign bus.busy       = (state_q == S_CONV);
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: slot-level display model checked every cycle,
// plus literal expectations at chosen slots.
module tb_seg7_scan_driver;
    localparam int RD = 32;
    localparam int FR = 4 * RD;

    logic clk = 1'b0;
    logic rst_a_p;
    seg7_scan_driver_if bus();

    seg7_scan_driver #(
        .REFRESH_DIV(RD), .AN_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .rst_a_p(rst_a_p), .bus(bus)
    );

    always #5 clk = ~clk;

    logic [6:0] SEGTAB [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    int P10 [4] = '{1, 10, 100, 1000};

    int         k;
    int         n_chk = 0;
    int         n_fail = 0;
    bit         cmp_en = 1'b0;
    bit         m_dec;
    logic [3:0] m_dpm;
    logic [6:0] m_pat [4];
    logic [6:0] m_slot0;

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 30)
                $display("FAIL %s at k=%0d: got %0h, expected %0h", nm, k, got, exp);
        end
    endtask

    // Model: k = clock edges since reset release; a slot lasts RD edges, frames start at k = RD + n*FR.
    always @(posedge clk or posedge rst_a_p) begin
        if (rst_a_p) begin
            k = 0;
            m_dec = 1'b0;
            m_dpm = 4'h0;
            for (int i = 0; i < 4; i++) m_pat[i] = 7'h3F;
            m_slot0 = 7'h3F;
        end else begin
            k++;
            if (k >= RD && (k - RD) % FR == 0) begin : cap
                int v;
                int d [4];
                bit dash, hz;
                logic [6:0] old0;
                v    = int'(bus.value);
                dash = bus.dec_mode && (v > 9999);
                for (int i = 0; i < 4; i++)
                    d[i] = bus.dec_mode ? (v / P10[i]) % 10 : (v >> (4 * i)) & 15;
                old0 = m_pat[0];
                for (int i = 0; i < 4; i++)
                    m_pat[i] = dash ? 7'h40 : SEGTAB[d[i]];
                if (bus.blank_lz && !dash) begin
                    for (int i = 1; i < 4; i++) begin
                        hz = 1'b1;
                        for (int j = i; j < 4; j++) if (d[j] != 0) hz = 1'b0;
                        if (hz) m_pat[i] = 7'h00;
                    end
                end
                m_slot0 = bus.dec_mode ? old0 : m_pat[0];
                m_dec   = bus.dec_mode;
                m_dpm   = bus.dp_mask;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin : cmp
            logic [3:0] ea;
            logic [6:0] es;
            logic       ed, ef, eb;
            int         s;
            if (k < RD) begin
                ea = 4'hF; es = 7'h7F; ed = 1'b1; ef = 1'b0; eb = 1'b0;
            end else begin
                s  = ((k - RD) / RD) % 4;
                ea = 4'(4'b0001 << s);
                ea = ~ea;
                es = ~((s == 0) ? m_slot0 : m_pat[s]);
                ed = ~m_dpm[s];
                ef = ((k - RD) % FR == 0);
                eb = m_dec && (((k - RD) % FR) < 16);
            end
            chk("model_an", 16'(bus.an), 16'(ea));
            chk("model_seg", 16'(bus.seg), 16'(es));
            chk("model_dp", 16'(bus.dp), 16'(ed));
            chk("model_frame_tick", 16'(bus.frame_tick), 16'(ef));
            chk("model_busy", 16'(bus.busy), 16'(eb));
        end
    end

    task automatic goto(input int t);
        int n = 0;
        while (k != t && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (k != t) begin
            n_fail++;
            $display("FAIL goto_timeout: got k=%0d, expected k=%0d", k, t);
        end
    endtask

    initial begin
        rst_a_p      = 1'b1;
        bus.value    = 16'hA5C3;
        bus.dec_mode = 1'b0;
        bus.blank_lz = 1'b0;
        bus.dp_mask  = 4'h0;
        #1 cmp_en = 1'b1;
        repeat (3) @(negedge clk);
        rst_a_p = 1'b0;

        // hex A5C3: digits 3,C,5,A
        goto(RD);      chk("ft_first", 16'(bus.frame_tick), 16'h1);
                       chk("an_s0", 16'(bus.an), 16'hE);  chk("hex_d0", 16'(bus.seg), 16'h30);
        goto(2*RD);    chk("an_s1", 16'(bus.an), 16'hD);  chk("hex_d1", 16'(bus.seg), 16'h46);
        goto(3*RD);    chk("an_s2", 16'(bus.an), 16'hB);  chk("hex_d2", 16'(bus.seg), 16'h12);
        goto(4*RD);    chk("an_s3", 16'(bus.an), 16'h7);  chk("hex_d3", 16'(bus.seg), 16'h08);

        // decimal 1234
        goto(150);     bus.dec_mode = 1'b1; bus.value = 16'd1234;
        goto(160);     chk("busy_start", 16'(bus.busy), 16'h1); chk("dec_s0_prev", 16'(bus.seg), 16'h30);
        goto(175);     chk("busy_last", 16'(bus.busy), 16'h1);
        goto(176);     chk("busy_fall", 16'(bus.busy), 16'h0);
        goto(192);     chk("dec1234_d1", 16'(bus.seg), 16'h30);
        goto(224);     chk("dec1234_d2", 16'(bus.seg), 16'h24);
        goto(256);     chk("dec1234_d3", 16'(bus.seg), 16'h79);

        // decimal 42 with leading-zero blanking
        goto(280);     bus.value = 16'd42; bus.blank_lz = 1'b1;
        goto(288);     chk("dec_s0_4", 16'(bus.seg), 16'h19);
        goto(320);     chk("dec42_d1", 16'(bus.seg), 16'h19);
        goto(352);     chk("dec42_d2_blank", 16'(bus.seg), 16'h7F);
        goto(384);     chk("dec42_d3_blank", 16'(bus.seg), 16'h7F);

        // decimal 0
        goto(410);     bus.value = 16'd0;
        goto(416);     chk("dec42_d0", 16'(bus.seg), 16'h24);
        goto(448);     chk("dec0_d1_blank", 16'(bus.seg), 16'h7F);

        // 10000 -> dashes, blanking ignored
        goto(540);     bus.value = 16'd10000;
        goto(544);     chk("dec0_d0", 16'(bus.seg), 16'h40);
        goto(576);     chk("dash_d1", 16'(bus.seg), 16'h3F);
        goto(640);     chk("dash_d3", 16'(bus.seg), 16'h3F);

        // hex 1111 with a mid-frame change to 2222
        goto(660);     bus.dec_mode = 1'b0; bus.value = 16'h1111; bus.blank_lz = 1'b0; bus.dp_mask = 4'b0100;
        goto(672);     chk("hex1_d0", 16'(bus.seg), 16'h79);
        goto(700);     bus.value = 16'h2222;
        goto(704);     chk("hold_d1", 16'(bus.seg), 16'h79); chk("dp_off_s1", 16'(bus.dp), 16'h1);
        goto(736);     chk("hold_d2", 16'(bus.seg), 16'h79); chk("dp_on_s2", 16'(bus.dp), 16'h0);
        goto(800);     chk("new_d0", 16'(bus.seg), 16'h24);
        goto(832);     chk("new_d1", 16'(bus.seg), 16'h24);

        // reset mid-conversion
        goto(920);     bus.dec_mode = 1'b1; bus.value = 16'd9999;
        goto(933);     chk("busy_before_rst", 16'(bus.busy), 16'h1);
        #2 rst_a_p = 1'b1; bus.value = 16'd5678;
        #1;
        chk("rst_an", 16'(bus.an), 16'hF);   chk("rst_seg", 16'(bus.seg), 16'h7F);
        chk("rst_dp", 16'(bus.dp), 16'h1);   chk("rst_busy", 16'(bus.busy), 16'h0);
        repeat (3) @(negedge clk);
        rst_a_p = 1'b0;
        goto(RD-1);    chk("no_ft_early", 16'(bus.frame_tick), 16'h0);
        goto(RD);      chk("ft_after_rst", 16'(bus.frame_tick), 16'h1); chk("rst_d0_zero", 16'(bus.seg), 16'h40);
        goto(2*RD);    chk("dec5678_d1", 16'(bus.seg), 16'h78);
        goto(3*RD);    chk("dec5678_d2", 16'(bus.seg), 16'h02);
        goto(4*RD);    chk("dec5678_d3", 16'(bus.seg), 16'h12);

        // 9999: largest non-dash value
        goto(150);     bus.value = 16'd9999; bus.blank_lz = 1'b1;
        goto(160);     chk("dec5678_d0", 16'(bus.seg), 16'h00);
        goto(192);     chk("dec9999_d1", 16'(bus.seg), 16'h10);
        goto(256);     chk("dec9999_d3", 16'(bus.seg), 16'h10);
        goto(290);

        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
